// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the EX-stage control bundle.
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef struct packed {
    logic                reg_dst;
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic [ALUOP_W-1:0]  alu_op;
  } ex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module load_use_detect
  import mips_pkg::*;
(
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [REG_AW-1:0]  ex_wr_addr,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs_addr,
  input  logic [REG_AW-1:0]  id_rt_addr,
  input  logic               id_reg_dst,
  input  logic               id_mem_write,
  input  logic [ALUOP_W-1:0] id_alu_op,
  output logic               load_use_c
);

  logic rt_read;
  logic rs_match;
  logic rt_match;
  logic ex_load;

  // RT is a source only for R-type, stores and branches; a loaded $zero never hazards.
  always_comb begin
    rt_read    = id_reg_dst | id_mem_write | (id_alu_op == ALUOP_BEQ);
    ex_load    = ex_valid & ex_mem_read & id_valid & (ex_wr_addr != '0);
    rs_match   = (ex_wr_addr == id_rs_addr);
    rt_match   = (ex_wr_addr == id_rt_addr) & rt_read;
    load_use_c = ex_load & (rs_match | rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating stall counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               RegDst_i,
  input  logic               ALUSrc_i,
  input  logic               RegWrite_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               MemtoReg_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [DATA_W-1:0]  RSdata_i,
  input  logic [DATA_W-1:0]  RTdata_i,
  input  logic [DATA_W-1:0]  imm_i,
  input  logic [REG_AW-1:0]  RSaddr_i,
  input  logic [REG_AW-1:0]  RTaddr_i,
  input  logic [REG_AW-1:0]  RDaddr_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               valid_o,
  output logic               RegDst_o,
  output logic               ALUSrc_o,
  output logic               RegWrite_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic [DATA_W-1:0]  RSdata_o,
  output logic [DATA_W-1:0]  RTdata_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [REG_AW-1:0]  RSaddr_o,
  output logic [REG_AW-1:0]  RTaddr_o,
  output logic [REG_AW-1:0]  RDaddr_o,
  output logic [FUNCT_W-1:0] funct_o,
  output logic [REG_AW-1:0]  WRaddr_o,
  output logic               stall_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  ex_ctrl_t            ctrl_q;
  ex_ctrl_t            ctrl_in;
  logic                valid_q;
  logic [DATA_W-1:0]   rs_data_q;
  logic [DATA_W-1:0]   rt_data_q;
  logic [DATA_W-1:0]   imm_q;
  logic [REG_AW-1:0]   rs_addr_q;
  logic [REG_AW-1:0]   rt_addr_q;
  logic [REG_AW-1:0]   rd_addr_q;
  logic [REG_AW-1:0]   wr_addr_q;
  logic [FUNCT_W-1:0]  funct_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                load_use_c;

  load_use_detect u_load_use_detect (
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q.mem_read),
    .ex_wr_addr   (wr_addr_q),
    .id_valid     (valid_i),
    .id_rs_addr   (RSaddr_i),
    .id_rt_addr   (RTaddr_i),
    .id_reg_dst   (RegDst_i),
    .id_mem_write (MemWrite_i),
    .id_alu_op    (ALUOp_i),
    .load_use_c   (load_use_c)
  );

  // Controls from ID, zeroed when ID carries no real instruction.
  always_comb begin
    ctrl_in            = '0;
    if (valid_i) begin
      ctrl_in.reg_dst    = RegDst_i;
      ctrl_in.alu_src    = ALUSrc_i;
      ctrl_in.reg_write  = RegWrite_i;
      ctrl_in.mem_read   = MemRead_i;
      ctrl_in.mem_write  = MemWrite_i;
      ctrl_in.mem_to_reg = MemtoReg_i;
      ctrl_in.alu_op     = ALUOp_i;
    end
  end

  // Priority: reset, hold, flush/load-use bubble, normal capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      funct_q   <= '0;
      cnt_q     <= '0;
    end else if (!hold_i) begin
      if (flush_i || load_use_c) begin
        valid_q   <= 1'b0;
        ctrl_q    <= '0;
        rs_data_q <= '0;
        rt_data_q <= '0;
        imm_q     <= '0;
        rs_addr_q <= '0;
        rt_addr_q <= '0;
        rd_addr_q <= '0;
        wr_addr_q <= '0;
        funct_q   <= '0;
        if (!flush_i && (cnt_q != '1)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        valid_q   <= valid_i;
        ctrl_q    <= ctrl_in;
        rs_data_q <= RSdata_i;
        rt_data_q <= RTdata_i;
        imm_q     <= imm_i;
        rs_addr_q <= RSaddr_i;
        rt_addr_q <= RTaddr_i;
        rd_addr_q <= RDaddr_i;
        wr_addr_q <= RegDst_i ? RDaddr_i : RTaddr_i;
        funct_q   <= funct_i;
      end
    end
  end

  // Stall request is suppressed when the bubble is already coming from a flush or a freeze.
  always_comb begin
    stall_o = load_use_c & ~flush_i & ~hold_i;
  end

  assign valid_o     = valid_q;
  assign RegDst_o    = ctrl_q.reg_dst;
  assign ALUSrc_o    = ctrl_q.alu_src;
  assign RegWrite_o  = ctrl_q.reg_write;
  assign MemRead_o   = ctrl_q.mem_read;
  assign MemWrite_o  = ctrl_q.mem_write;
  assign MemtoReg_o  = ctrl_q.mem_to_reg;
  assign ALUOp_o     = ctrl_q.alu_op;
  assign RSdata_o    = rs_data_q;
  assign RTdata_o    = rt_data_q;
  assign imm_o       = imm_q;
  assign RSaddr_o    = rs_addr_q;
  assign RTaddr_o    = rt_addr_q;
  assign RDaddr_o    = rd_addr_q;
  assign funct_o     = funct_q;
  assign WRaddr_o    = wr_addr_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, vi, regdst, alusrc, regwrite, memread, memwrite, memtoreg, flush, hold;
  logic [2:0]  aluop;
  logic [31:0] rsdata, rtdata, imm;
  logic [4:0]  rsa, rta, rda;
  logic [5:0]  funct;

  logic        valid_o, regdst_o, alusrc_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, stall_o;
  logic [2:0]  aluop_o;
  logic [31:0] rsdata_o, rtdata_o, imm_o;
  logic [4:0]  rsa_o, rta_o, rda_o, wraddr_o;
  logic [5:0]  funct_o;
  logic [15:0] cnt_o;

  logic        d2_valid, d2_regdst, d2_alusrc, d2_regwrite, d2_memread, d2_memwrite, d2_memtoreg, d2_stall;
  logic [2:0]  d2_aluop;
  logic [31:0] d2_rsdata, d2_rtdata, d2_imm;
  logic [4:0]  d2_rsa, d2_rta, d2_rda, d2_wraddr;
  logic [5:0]  d2_funct;
  logic [1:0]  d2_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit        valid, regdst, alusrc, regwrite, memread, memwrite, memtoreg;
    bit [2:0]  aluop;
    bit [31:0] rsd, rtd, imm;
    bit [4:0]  rs, rt, rd, wr;
    bit [5:0]  funct;
  } ex_t;

  ex_t m;
  int  m_cnt16;
  int  m_cnt2;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vi),
    .RegDst_i(regdst), .ALUSrc_i(alusrc), .RegWrite_i(regwrite), .MemRead_i(memread),
    .MemWrite_i(memwrite), .MemtoReg_i(memtoreg), .ALUOp_i(aluop),
    .RSdata_i(rsdata), .RTdata_i(rtdata), .imm_i(imm),
    .RSaddr_i(rsa), .RTaddr_i(rta), .RDaddr_i(rda), .funct_i(funct),
    .flush_i(flush), .hold_i(hold),
    .valid_o(valid_o), .RegDst_o(regdst_o), .ALUSrc_o(alusrc_o), .RegWrite_o(regwrite_o),
    .MemRead_o(memread_o), .MemWrite_o(memwrite_o), .MemtoReg_o(memtoreg_o), .ALUOp_o(aluop_o),
    .RSdata_o(rsdata_o), .RTdata_o(rtdata_o), .imm_o(imm_o),
    .RSaddr_o(rsa_o), .RTaddr_o(rta_o), .RDaddr_o(rda_o), .funct_o(funct_o),
    .WRaddr_o(wraddr_o), .stall_o(stall_o), .stall_cnt_o(cnt_o)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(vi),
    .RegDst_i(regdst), .ALUSrc_i(alusrc), .RegWrite_i(regwrite), .MemRead_i(memread),
    .MemWrite_i(memwrite), .MemtoReg_i(memtoreg), .ALUOp_i(aluop),
    .RSdata_i(rsdata), .RTdata_i(rtdata), .imm_i(imm),
    .RSaddr_i(rsa), .RTaddr_i(rta), .RDaddr_i(rda), .funct_i(funct),
    .flush_i(flush), .hold_i(hold),
    .valid_o(d2_valid), .RegDst_o(d2_regdst), .ALUSrc_o(d2_alusrc), .RegWrite_o(d2_regwrite),
    .MemRead_o(d2_memread), .MemWrite_o(d2_memwrite), .MemtoReg_o(d2_memtoreg), .ALUOp_o(d2_aluop),
    .RSdata_o(d2_rsdata), .RTdata_o(d2_rtdata), .imm_o(d2_imm),
    .RSaddr_o(d2_rsa), .RTaddr_o(d2_rta), .RDaddr_o(d2_rda), .funct_o(d2_funct),
    .WRaddr_o(d2_wraddr), .stall_o(d2_stall), .stall_cnt_o(d2_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // A load in EX blocks any ID instruction that reads the loaded register.
  function automatic bit model_hazard();
    bit rt_read;
    rt_read = regdst || memwrite || (aluop == 3'b001);
    return m.valid && m.memread && vi && (m.wr != 0) &&
           ((m.wr == rsa) || (rt_read && (m.wr == rta)));
  endfunction

  function automatic bit model_stall();
    return model_hazard() && !flush && !hold;
  endfunction

  task automatic model_update();
    ex_t z;
    bit  hz;
    z  = '{default: 0};
    hz = model_hazard();
    if (rst) begin
      m = z; m_cnt16 = 0; m_cnt2 = 0;
    end else if (hold) begin
      m = m;
    end else if (flush) begin
      m = z;
    end else if (hz) begin
      m = z;
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m.valid    = vi;
      m.regdst   = vi && regdst;
      m.alusrc   = vi && alusrc;
      m.regwrite = vi && regwrite;
      m.memread  = vi && memread;
      m.memwrite = vi && memwrite;
      m.memtoreg = vi && memtoreg;
      m.aluop    = vi ? aluop : 3'd0;
      m.rsd = rsdata; m.rtd = rtdata; m.imm = imm;
      m.rs = rsa; m.rt = rta; m.rd = rda; m.funct = funct;
      m.wr = regdst ? rda : rta;
    end
  endtask

  task automatic compare_outputs();
    check("valid", 32'(valid_o), 32'(m.valid));
    check("regdst", 32'(regdst_o), 32'(m.regdst));
    check("alusrc", 32'(alusrc_o), 32'(m.alusrc));
    check("regwrite", 32'(regwrite_o), 32'(m.regwrite));
    check("memread", 32'(memread_o), 32'(m.memread));
    check("memwrite", 32'(memwrite_o), 32'(m.memwrite));
    check("memtoreg", 32'(memtoreg_o), 32'(m.memtoreg));
    check("aluop", 32'(aluop_o), 32'(m.aluop));
    check("rsdata", rsdata_o, m.rsd);
    check("rtdata", rtdata_o, m.rtd);
    check("imm", imm_o, m.imm);
    check("rsaddr", 32'(rsa_o), 32'(m.rs));
    check("rtaddr", 32'(rta_o), 32'(m.rt));
    check("rdaddr", 32'(rda_o), 32'(m.rd));
    check("funct", 32'(funct_o), 32'(m.funct));
    check("wraddr", 32'(wraddr_o), 32'(m.wr));
    check("cnt16", 32'(cnt_o), 32'(m_cnt16));
    check("valid_w2", 32'(d2_valid), 32'(m.valid));
    check("wraddr_w2", 32'(d2_wraddr), 32'(m.wr));
    check("cnt2", 32'(d2_cnt), 32'(m_cnt2));
  endtask

  // Check the combinational stall, clock once, then check the registered state.
  task automatic step();
    #1;
    check("stall", 32'(stall_o), 32'(model_stall()));
    check("stall_w2", 32'(d2_stall), 32'(model_stall()));
    @(posedge clk);
    model_update();
    #1;
    compare_outputs();
  endtask

  task automatic set_nop();
    vi = 0; regdst = 0; alusrc = 0; regwrite = 0; memread = 0; memwrite = 0; memtoreg = 0;
    aluop = 3'd0; rsdata = 0; rtdata = 0; imm = 0; rsa = 0; rta = 0; rda = 0; funct = 0;
    flush = 0; hold = 0; rst = 0;
  endtask

  task automatic set_lw(input logic [4:0] rt, input logic [4:0] rs);
    set_nop();
    vi = 1; alusrc = 1; regwrite = 1; memread = 1; memtoreg = 1; aluop = 3'b000;
    rsa = rs; rta = rt; imm = 32'h10;
  endtask

  task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd);
    set_nop();
    vi = 1; regdst = 1; regwrite = 1; aluop = 3'b011;
    rsa = rs; rta = rt; rda = rd; rsdata = rsd; funct = 6'h20;
  endtask

  task automatic set_addi(input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    vi = 1; alusrc = 1; regwrite = 1; aluop = 3'b000; rsa = rs; rta = rt; imm = 32'h7;
  endtask

  task automatic do_reset();
    set_nop();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    int saved;
    m = '{default: 0};
    m_cnt16 = 0;
    m_cnt2  = 0;
    set_nop();
    rst = 1;
    @(posedge clk);
    model_update();
    #1;

    // Reset state, and no stall possible right after reset
    do_reset();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_memread", 32'(memread_o), 32'd0);
    check("rst_cnt", 32'(cnt_o), 32'd0);
    set_rtype(5'd0, 5'd0, 5'd1, 32'h1);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);

    // Normal R-type capture
    set_rtype(5'd2, 5'd3, 5'd4, 32'h5);
    step();
    check("rtype_wr", 32'(wraddr_o), 32'd4);
    check("rtype_rsdata", rsdata_o, 32'h5);
    check("rtype_valid", 32'(valid_o), 32'd1);

    // Load-use: one-cycle stall, bubble, counter 0 -> 1, then capture
    do_reset();
    set_lw(5'd8, 5'd1);
    step();
    set_rtype(5'd8, 5'd9, 5'd10, 32'hA);
    #1;
    check("lu_stall", 32'(stall_o), 32'd1);
    step();
    check("lu_bubble_valid", 32'(valid_o), 32'd0);
    check("lu_bubble_rw", 32'(regwrite_o), 32'd0);
    check("lu_cnt", 32'(cnt_o), 32'd1);
    #1;
    check("lu_stall_drop", 32'(stall_o), 32'd0);
    step();
    check("lu_add_valid", 32'(valid_o), 32'd1);
    check("lu_add_wr", 32'(wraddr_o), 32'd10);

    // Load to $0, and load whose RT target is not read by addi
    set_lw(5'd0, 5'd1);
    step();
    set_rtype(5'd0, 5'd0, 5'd5, 32'h3);
    #1;
    check("lw0_stall", 32'(stall_o), 32'd0);
    step();
    set_lw(5'd8, 5'd1);
    step();
    set_addi(5'd2, 5'd8);
    #1;
    check("addi_rt_stall", 32'(stall_o), 32'd0);
    step();

    // Flush together with load-use: one bubble, counter unchanged
    set_lw(5'd8, 5'd1);
    step();
    saved = 32'(cnt_o);
    set_rtype(5'd8, 5'd3, 5'd4, 32'h1);
    flush = 1;
    #1;
    check("flush_stall", 32'(stall_o), 32'd0);
    step();
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_cnt", 32'(cnt_o), 32'(saved));

    // Hold for three cycles during a hazard, then the stall happens
    set_lw(5'd8, 5'd1);
    step();
    saved = 32'(cnt_o);
    set_rtype(5'd8, 5'd3, 5'd4, 32'h1);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_memread", 32'(memread_o), 32'd1);
      check("hold_cnt", 32'(cnt_o), 32'(saved));
    end
    hold = 0;
    #1;
    check("hold_release_stall", 32'(stall_o), 32'd1);
    step();
    check("hold_release_cnt", 32'(cnt_o), 32'(saved + 1));

    // Saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_lw(5'd8, 5'd1);
      step();
      set_rtype(5'd8, 5'd3, 5'd4, 32'h1);
      step();
      step();
      if (i == 3) check("sat4", 32'(d2_cnt), 32'd3);
    end
    check("sat5", 32'(d2_cnt), 32'd3);
    check("sat5_wide", 32'(cnt_o), 32'd5);

    // Random traffic with small register numbers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      vi       = ($urandom_range(0, 99) < 85);
      regdst   = 1'($urandom);
      alusrc   = 1'($urandom);
      regwrite = 1'($urandom);
      memread  = ($urandom_range(0, 99) < 40);
      memwrite = ($urandom_range(0, 99) < 20);
      memtoreg = 1'($urandom);
      aluop    = 3'($urandom_range(0, 3));
      rsdata   = $urandom;
      rtdata   = $urandom;
      imm      = $urandom;
      rsa      = 5'($urandom_range(0, 3));
      rta      = 5'($urandom_range(0, 3));
      rda      = 5'($urandom_range(0, 3));
      funct    = 6'($urandom);
      flush    = ($urandom_range(0, 99) < 10);
      hold     = ($urandom_range(0, 99) < 10);
      rst      = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
